io_responder: RTL and testbench

Memory-mapped I/O responder at the 0x8000_00xx region. It is the completion side of the memory controller's `io_trans`/`io_recv` strobes. It decodes word addresses, holds UART transmit and receive bytes in one-entry buffers, and maintains cycle and retired-instruction counters. It returns a registered 32-bit read word in the same slot as synchronous dmem read data, so the writeback mux treats I/O and dmem loads identically.

---
 rtl/io_responder_pkg.sv | 35 +++
 rtl/io_byte_buffer.sv | 27 ++
 rtl/io_responder.sv | 100 ++++++++++
 tb/tb_io_responder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/io_responder_pkg.sv
// Shared I/O word map and decode helper for the 0x8000_00xx responder region.
// The memory controller imports this package, so both sides agree on the offsets.
package io_responder_pkg;

   localparam logic [7:0] IO_STATUS  = 8'h00;
   localparam logic [7:0] IO_RX_DATA = 8'h04;
   localparam logic [7:0] IO_TX_DATA = 8'h08;
   localparam logic [7:0] IO_CYCLE   = 8'h10;
   localparam logic [7:0] IO_INSTRET = 8'h14;
   localparam logic [7:0] IO_CNT_CLR = 8'h18;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_STATUS,
      REG_RX_DATA,
      REG_TX_DATA,
      REG_CYCLE,
      REG_INSTRET,
      REG_CNT_CLR
   } io_reg_e;

   // Word index is the zero-extended addr[ADDR_LSB-1:2]; byte lane bits never reach here.
   function automatic io_reg_e decode_word(input logic [29:0] word_idx);
      case (word_idx)
         30'(IO_STATUS  >> 2): return REG_STATUS;
         30'(IO_RX_DATA >> 2): return REG_RX_DATA;
         30'(IO_TX_DATA >> 2): return REG_TX_DATA;
         30'(IO_CYCLE   >> 2): return REG_CYCLE;
         30'(IO_INSTRET >> 2): return REG_INSTRET;
         30'(IO_CNT_CLR >> 2): return REG_CNT_CLR;
         default:              return REG_NONE;
      endcase
   endfunction

endpackage

// File: rtl/io_byte_buffer.sv
// One-entry 8-bit buffer: push lands only when empty, pop empties only when full.
// The held byte survives a pop so a drained TX still shows its last value.
module io_byte_buffer (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   output logic       full,
   output logic [7:0] data
);

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         full <= 1'b0;
         // NOTE: the data byte is reset too because it is architecturally visible after reset.
         data <= '0;
      end else if (push && !full) begin
         full <= 1'b1;
         data <= push_data;
      end else if (pop && full) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/io_responder.sv
// Memory-mapped I/O responder: UART byte buffers, cycle/instret counters and a
// registered read word that lines up with synchronous dmem read data.
module io_responder
   import io_responder_pkg::*;
#(
   parameter int ADDR_LSB = 8
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [31:0] addr,
   input  logic [3:0]  io_trans,
   input  logic        io_recv,
   input  logic        io_ena,
   input  logic [31:0] wr_data,
   input  logic        inst_retired,
   output logic [31:0] io_rd_data,
   output logic [7:0]  uart_tx_data,
   output logic        uart_tx_valid,
   input  logic        uart_tx_ready,
   input  logic [7:0]  uart_rx_data,
   input  logic        uart_rx_valid,
   output logic        uart_rx_ready
);

   io_reg_e     sel;
   logic        tx_push;
   logic        rx_pop;
   logic        cnt_clr;
   logic        tx_full;
   logic        rx_full;
   logic [7:0]  rx_byte;
   logic [31:0] cycle_cnt;
   logic [31:0] instret_cnt;
   logic [31:0] rd_next;

   assign sel = decode_word(30'(addr[ADDR_LSB-1:2]));

   // Side effects need io_ena; the read word itself is produced regardless.
   assign tx_push = io_ena && io_trans[0] && (sel == REG_TX_DATA);
   assign rx_pop  = io_ena && io_recv && (sel == REG_RX_DATA);
   assign cnt_clr = io_ena && (|io_trans) && (sel == REG_CNT_CLR);

   io_byte_buffer u_tx_buf (
      .Clock     (Clock),
      .Reset     (Reset),
      .push      (tx_push),
      .push_data (wr_data[7:0]),
      .pop       (uart_tx_ready),
      .full      (tx_full),
      .data      (uart_tx_data)
   );

   io_byte_buffer u_rx_buf (
      .Clock     (Clock),
      .Reset     (Reset),
      .push      (uart_rx_valid),
      .push_data (uart_rx_data),
      .pop       (rx_pop),
      .full      (rx_full),
      .data      (rx_byte)
   );

   // Masking with Reset keeps a pending byte from handshaking during the reset cycle.
   assign uart_tx_valid = tx_full && Reset;
   assign uart_rx_ready = !rx_full;

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else if (cnt_clr) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         if (inst_retired) instret_cnt <= instret_cnt + 32'd1;
      end
   end

   always_comb begin
      // NOTE: default first so no case path leaves rd_next unassigned (no latch).
      rd_next = '0;
      case (sel)
         REG_STATUS:  rd_next = {30'b0, rx_full, !tx_full};
         REG_RX_DATA: rd_next = {24'b0, rx_byte};
         REG_CYCLE:   rd_next = cycle_cnt;
         REG_INSTRET: rd_next = instret_cnt;
         default:     rd_next = '0;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Reset) io_rd_data <= '0;
      else if (io_recv) io_rd_data <= rd_next;
   end

   logic unused_bits;
   assign unused_bits = ^{addr[31:ADDR_LSB], addr[1:0], wr_data[31:8]};

endmodule

// File: tb/tb_io_responder.sv
// Directed bench for io_responder: reads push expected words into a scoreboard
// queue, and a monitor compares io_rd_data on the cycle after each sampled read.
module tb_io_responder;
   import io_responder_pkg::*;

   localparam logic [31:0] A_STATUS  = 32'h8000_0000;
   localparam logic [31:0] A_RX      = 32'h8000_0004;
   localparam logic [31:0] A_TX      = 32'h8000_0008;
   localparam logic [31:0] A_CYCLE   = 32'h8000_0010;
   localparam logic [31:0] A_INSTRET = 32'h8000_0014;
   localparam logic [31:0] A_CLR     = 32'h8000_0018;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [31:0] addr;
   logic [3:0]  io_trans;
   logic        io_recv;
   logic        io_ena;
   logic [31:0] wr_data;
   logic        inst_retired;
   logic [31:0] io_rd_data;
   logic [7:0]  uart_tx_data;
   logic        uart_tx_valid;
   logic        uart_tx_ready;
   logic [7:0]  uart_rx_data;
   logic        uart_rx_valid;
   logic        uart_rx_ready;

   typedef struct {
      logic [31:0] a;
      logic [31:0] exp;
   } rd_exp_t;

   rd_exp_t sb_q[$];
   logic    rd_pending = 1'b0;
   int      checks = 0;
   int      errors = 0;

   io_responder #(.ADDR_LSB(8)) dut (
      .Clock         (Clock),
      .Reset         (Reset),
      .addr          (addr),
      .io_trans      (io_trans),
      .io_recv       (io_recv),
      .io_ena        (io_ena),
      .wr_data       (wr_data),
      .inst_retired  (inst_retired),
      .io_rd_data    (io_rd_data),
      .uart_tx_data  (uart_tx_data),
      .uart_tx_valid (uart_tx_valid),
      .uart_tx_ready (uart_tx_ready),
      .uart_rx_data  (uart_rx_data),
      .uart_rx_valid (uart_rx_valid),
      .uart_rx_ready (uart_rx_ready)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: a read sampled at a posedge presents its word by the following negedge.
   always @(posedge Clock) rd_pending <= io_recv;

   always @(negedge Clock) begin
      if (rd_pending) begin
         if (sb_q.size() == 0) begin
            check("unexpected_read", 32'd1, 32'd0);
         end else begin
            rd_exp_t e;
            e = sb_q.pop_front();
            check($sformatf("rd@%h", e.a), io_rd_data, e.exp);
         end
      end
   end

   task automatic rd(input logic [31:0] a, input logic [31:0] exp, input logic ena);
      rd_exp_t e;
      e.a     = a;
      e.exp   = exp;
      sb_q.push_back(e);
      addr    = a;
      io_ena  = ena;
      io_recv = 1'b1;
      @(negedge Clock);
      io_recv = 1'b0;
      io_ena  = 1'b1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                     input logic ena);
      addr     = a;
      wr_data  = d;
      io_trans = be;
      io_ena   = ena;
      @(negedge Clock);
      io_trans = 4'b0;
      io_ena   = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      Reset = 1'b0; addr = '0; io_trans = '0; io_recv = 1'b0; io_ena = 1'b1;
      wr_data = '0; inst_retired = 1'b0; uart_tx_ready = 1'b0;
      uart_rx_data = '0; uart_rx_valid = 1'b0;
      repeat (2) @(negedge Clock);
      Reset = 1'b1;

      // Reset state
      check("rst_rx_ready", 32'(uart_rx_ready), 32'd1);
      check("rst_tx_valid", 32'(uart_tx_valid), 32'd0);
      check("rst_tx_data",  32'(uart_tx_data),  32'd0);
      check("rst_rd_data",  io_rd_data,         32'd0);
      rd(A_STATUS, 32'h1, 1'b1);
      rd(A_CYCLE,  32'd1, 1'b1);

      // TX buffer
      wr(A_TX, 32'h7a, 4'b0001, 1'b1);
      check("tx_valid_set", 32'(uart_tx_valid), 32'd1);
      check("tx_data_7a",   32'(uart_tx_data),  32'h7a);
      rd(A_STATUS, 32'h0, 1'b1);
      wr(A_TX, 32'h55, 4'b0001, 1'b1);
      check("tx_drop_full", 32'(uart_tx_data), 32'h7a);
      uart_tx_ready = 1'b1;
      @(negedge Clock);
      uart_tx_ready = 1'b0;
      check("tx_hs_valid", 32'(uart_tx_valid), 32'd0);
      check("tx_hs_data",  32'(uart_tx_data),  32'h7a);
      wr(A_TX, 32'h11, 4'b0010, 1'b1);
      check("tx_need_be0", 32'(uart_tx_valid), 32'd0);
      wr(A_TX, 32'h33, 4'b0001, 1'b1);
      check("tx_data_33", 32'(uart_tx_data), 32'h33);
      uart_tx_ready = 1'b1;
      wr(A_TX, 32'h44, 4'b0001, 1'b1);
      uart_tx_ready = 1'b0;
      check("tx_hs_store_valid", 32'(uart_tx_valid), 32'd0);
      check("tx_hs_store_data",  32'(uart_tx_data),  32'h33);
      wr(A_TX, 32'h66, 4'b0001, 1'b0);
      check("tx_ena_low", 32'(uart_tx_valid), 32'd0);

      // RX buffer
      uart_rx_data = 8'h41; uart_rx_valid = 1'b1;
      @(negedge Clock);
      uart_rx_valid = 1'b0;
      check("rx_ready_low", 32'(uart_rx_ready), 32'd0);
      rd(A_STATUS, 32'h3, 1'b1);
      uart_rx_data = 8'h42; uart_rx_valid = 1'b1;
      @(negedge Clock);
      uart_rx_valid = 1'b0;
      rd(A_RX,     32'h41, 1'b0);
      rd(A_STATUS, 32'h3,  1'b1);
      rd(A_RX,     32'h41, 1'b1);
      check("rx_ready_pop", 32'(uart_rx_ready), 32'd1);
      rd(A_STATUS, 32'h1,  1'b1);
      rd(A_RX,     32'h41, 1'b1);
      rd(A_STATUS, 32'h1,  1'b1);

      // Decode boundaries
      rd(32'h8000_0003, 32'h1, 1'b1);
      rd(32'h8000_0100, 32'h1, 1'b1);
      rd(32'h8000_0020, 32'h0, 1'b1);
      rd(A_TX,          32'h0, 1'b1);
      rd(A_CLR,         32'h0, 1'b1);
      rd(32'h8000_001c, 32'h0, 1'b1);

      // Counters
      wr(A_CLR, 32'h0, 4'b1111, 1'b1);
      rd(A_CYCLE,   32'd0, 1'b1);
      rd(A_INSTRET, 32'd0, 1'b1);
      wr(A_CLR, 32'h0, 4'b0100, 1'b1);
      repeat (100) @(negedge Clock);
      rd(A_CYCLE, 32'h64, 1'b1);
      for (int i = 0; i < 5; i++) begin
         inst_retired = 1'b1;
         @(negedge Clock);
         inst_retired = 1'b0;
         @(negedge Clock);
      end
      wr(A_CLR, 32'h0, 4'b0001, 1'b0);
      rd(A_INSTRET, 32'd5, 1'b1);
      inst_retired = 1'b1;
      wr(A_CLR, 32'h0, 4'b0001, 1'b1);
      inst_retired = 1'b0;
      rd(A_INSTRET, 32'd0, 1'b1);

      // Cycle counter wrap
      force dut.cycle_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.cycle_cnt;
      rd(A_CYCLE, 32'hFFFF_FFFF, 1'b1);
      rd(A_CYCLE, 32'h0, 1'b1);

      // Reset while a TX byte is pending
      rd(A_STATUS, 32'h1, 1'b1);
      wr(A_TX, 32'h99, 4'b0001, 1'b1);
      check("tx_pending", 32'(uart_tx_valid), 32'd1);
      uart_tx_ready = 1'b1;
      Reset = 1'b0;
      #1;
      check("tx_valid_in_reset", 32'(uart_tx_valid), 32'd0);
      @(negedge Clock);
      Reset = 1'b1;
      uart_tx_ready = 1'b0;
      check("rst2_tx_valid", 32'(uart_tx_valid), 32'd0);
      check("rst2_tx_data",  32'(uart_tx_data),  32'd0);
      check("rst2_rd_data",  io_rd_data,         32'd0);
      rd(A_CYCLE, 32'd0, 1'b1);

      repeat (2) @(negedge Clock);
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
